logic_axi4_stream_mux_arbiter: RTL and testbench
================================================

Name: logic_axi4_stream_mux_arbiter

Overview:
Packet-aware round-robin arbiter that sequences the AXI4-Stream N:1 mux datapath. It watches per-input tvalid and the muxed tx handshake, and issues a registered one-hot grant plus a binary select for the mux. The grant is held until end of packet, or until a beat limit is reached, so packets from different inputs never interleave.

Parameters:
INPUTS, 16, number of requesting streams; legal range is >= 1.
TLAST, 1, 1 = release grant on a handshaked tx_tlast beat; 0 = ignore tlast.
MAX_BEATS, 0, beats per grant before forced release; 0 = unlimited.
INDEX_WIDTH, (INPUTS > 1) ? $clog2(INPUTS) : 1, width of grant_index (derived; do not override).

Ports:
aclk  input  1  clock; all logic is on the rising edge.
areset  input  1  reset; synchronous, active-high.
rx_tvalid  input  INPUTS  per-input request, which is the input's tvalid.
tx_tvalid  input  1  muxed output valid.
tx_tready  input  1  downstream ready.
tx_tlast  input  1  muxed output tlast.
grant  output  INPUTS  one-hot grant, registered.
grant_index  output  INDEX_WIDTH  binary index of the granted input, registered.
grant_valid  output  1  a grant is active, registered.

Behaviour:
- Reset values: grant = 0, grant_index = 0, grant_valid = 0, state = IDLE, beat counter = 0.
- After reset, the priority pointer ptr = INPUTS-1, so input 0 has highest priority first.
- Beat: a cycle with grant_valid & tx_tvalid & tx_tready.
- Release condition (rel) is asserted on a beat when either:
  - TLAST = 1 and tx_tlast = 1, or
  - MAX_BEATS != 0 and beat_cnt == MAX_BEATS-1.
- The beat counter is $clog2(MAX_BEATS+1) bits wide:
  - clears on every new grant;
  - increments on each beat;
  - never wraps, because rel fires first.
- With TLAST = 0 and MAX_BEATS = 0, a grant is held while its input keeps requesting:
  - rel also fires when the granted rx_tvalid is 0 and no beat occurs in that cycle (idle holder).
- Round-robin pick: the first set bit of rx_tvalid searching ptr+1, ptr+2, … with wrap modulo INPUTS.
- FSM, IDLE:
  - if any rx_tvalid is set, register the pick and go to LOCKED;
  - grant_valid rises one cycle after the request, so arbitration latency is 1 cycle;
  - otherwise stay in IDLE.
- FSM, LOCKED:
  - grant is held stable; ptr = grant_index.
  - On rel, re-arbitrate in the same cycle over the current rx_tvalid, searching from grant_index+1.
  - The releasing input is considered last, so it wins again only if it is the sole requester.
  - A hit registers the new grant for the next cycle, giving zero bubble between packets.
  - No requester: clear grant and go to IDLE.
- The grant never changes except on rel or reset; a stalled beat (tx_tready = 0) holds everything.
- Invariants:
  - grant is one-hot or zero;
  - grant_valid == |grant;
  - grant_index always matches grant.
- INPUTS = 1: the pick is always 0; the lock and release rules still apply.
- Reset mid-packet: grant drops in the next cycle regardless of state; the partial packet is abandoned. Upstream is responsible for flushing it.
- Simultaneous rel and reset: reset wins.

Decomposition:
- Shared package logic_axi4_stream_mux_arbiter_pkg:
  - state_t enum {IDLE, LOCKED};
  - index-width function for INPUTS.
- Sub-module logic_round_robin_pick (purely combinational):
  - inputs: request vector and pointer;
  - outputs: one-hot grant, index and hit flag;
  - implementation: rotate by ptr+1, priority-encode, then rotate back.
- The top holds the FSM, the pointer, the beat counter and the output registers.

Test Plan:
1. INPUTS = 4, TLAST = 1, rx_tvalid = 4'b0100 at cycle 0 -> grant = 4'b0100, grant_index = 2 and grant_valid = 1 at cycle 1.
2. All 4 inputs request continuously; each sends 1-beat packets (tlast = 1), tx_tready = 1 -> grant_index sequence 0,1,2,3,0,… with no idle cycle between grants.
3. Inputs 1 and 3 request; input 1 sends a 3-beat packet with tready low for 2 cycles mid-packet -> grant stays 1 through all stalls, then moves to 3 on the same edge as the tlast beat.
4. TLAST = 0, MAX_BEATS = 4, inputs 0 and 2 request continuously -> grant alternates 0,2,0 every 4 beats; the counter restarts at 0 on each switch.
5. Only input 1 requests and sends back-to-back packets -> grant remains 1 across packets with no deassertion.
6. areset asserted on beat 2 of a 5-beat packet from input 3 -> grant = 0 and grant_valid = 0 next cycle; after release, with inputs 0 and 3 requesting, input 0 is granted first.

Source files
------------

// File: rtl/logic_axi4_stream_mux_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// logic_axi4_stream_mux_arbiter_pkg
// Shared types and helpers for the packet-aware AXI4-Stream mux arbiter.
//   state_t     : arbiter FSM state (IDLE / LOCKED)
//   index_width : width of a binary index able to address INPUTS streams
//                 (at least 1 bit, so INPUTS = 1 still gets a real port)
// ----------------------------------------------------------------------------
package logic_axi4_stream_mux_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int index_width(input int inputs);
        return (inputs > 1) ? $clog2(inputs) : 1;
    endfunction

endpackage : logic_axi4_stream_mux_arbiter_pkg

// File: rtl/logic_axi4_stream_mux_arbiter_pick.sv
// ----------------------------------------------------------------------------
// logic_round_robin_pick
// Purely combinational round-robin picker. Finds the first set request bit
// searching ptr+1, ptr+2, ... with wrap modulo INPUTS, so the input at ptr
// is considered last.
// Ports:
//   req        in  [INPUTS-1:0]      request vector
//   ptr        in  [INDEX_WIDTH-1:0] last-served index
//   pick_grant out [INPUTS-1:0]      one-hot winner (zero if no request)
//   pick_index out [INDEX_WIDTH-1:0] binary winner (zero if no request)
//   pick_hit   out                   at least one request present
// ----------------------------------------------------------------------------
module logic_round_robin_pick
    import logic_axi4_stream_mux_arbiter_pkg::*;
#(
    parameter int INPUTS      = 16,
    parameter int INDEX_WIDTH = index_width(INPUTS)
) (
    input  logic [INPUTS-1:0]      req,
    input  logic [INDEX_WIDTH-1:0] ptr,
    output logic [INPUTS-1:0]      pick_grant,
    output logic [INDEX_WIDTH-1:0] pick_index,
    output logic                   pick_hit
);

    int                    start_s;
    int                    idx_s;
    logic [2*INPUTS-1:0]   dbl_req_s;
    logic [2*INPUTS-1:0]   dbl_low_s;
    logic [INPUTS-1:0]     rot_s;
    logic [INPUTS-1:0]     low_s;

    // Rotate so ptr+1 sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        start_s    = (int'(ptr) + 1) % INPUTS;
        // Doubling the vector turns the rotate into a plain shift.
        dbl_req_s  = {req, req} >> start_s;
        rot_s      = dbl_req_s[INPUTS-1:0];
        // Two's-complement trick keeps only the lowest set bit.
        low_s      = rot_s & (~rot_s + INPUTS'(1));
        dbl_low_s  = {low_s, low_s} << start_s;
        pick_grant = dbl_low_s[2*INPUTS-1:INPUTS];
        pick_hit   = |req;
        idx_s      = 0;
        for (int i = 0; i < INPUTS; i++) begin
            idx_s = (|(pick_grant & (INPUTS'(1) << i))) ? i : idx_s;
        end
        pick_index = INDEX_WIDTH'(idx_s);
    end

endmodule : logic_round_robin_pick

// File: rtl/logic_axi4_stream_mux_arbiter.sv
// ----------------------------------------------------------------------------
// logic_axi4_stream_mux_arbiter
// Packet-aware round-robin arbiter sequencing an AXI4-Stream N:1 mux. A grant
// is held until the end of packet (TLAST), a beat limit (MAX_BEATS), or, when
// both are disabled, until the holder stops requesting. Re-arbitration on
// release happens in the same cycle, so back-to-back packets have no bubble.
// Ports:
//   aclk        in                     clock, rising edge
//   areset      in                     synchronous active-high reset
//   rx_tvalid   in  [INPUTS-1:0]       per-input request (input tvalid)
//   tx_tvalid   in                     muxed output valid
//   tx_tready   in                     downstream ready
//   tx_tlast    in                     muxed output tlast
//   grant       out [INPUTS-1:0]       registered one-hot grant
//   grant_index out [INDEX_WIDTH-1:0]  registered binary grant index
//   grant_valid out                    registered "grant active"
// ----------------------------------------------------------------------------
module logic_axi4_stream_mux_arbiter
    import logic_axi4_stream_mux_arbiter_pkg::*;
#(
    parameter int INPUTS      = 16,
    parameter int TLAST       = 1,
    parameter int MAX_BEATS   = 0,
    parameter int INDEX_WIDTH = index_width(INPUTS)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [INPUTS-1:0]      rx_tvalid,
    input  logic                   tx_tvalid,
    input  logic                   tx_tready,
    input  logic                   tx_tlast,
    output logic [INPUTS-1:0]      grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   grant_valid
);

    localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((MAX_BEATS > 0) ? (MAX_BEATS - 1) : 0);
    localparam logic [INDEX_WIDTH-1:0] PTR_INIT = INDEX_WIDTH'(INPUTS - 1);

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [INPUTS-1:0]        grant_q, grant_d;
    logic [INDEX_WIDTH-1:0]   grant_index_q, grant_index_d;
    logic                     grant_valid_q, grant_valid_d;

    logic                     beat_s;
    logic                     rel_s;
    logic [INPUTS-1:0]        pick_grant_s;
    logic [INDEX_WIDTH-1:0]   pick_index_s;
    logic                     pick_hit_s;

    // ptr_q always equals the last granted index (or INPUTS-1 after reset),
    // so the releasing input is naturally searched last.
    logic_round_robin_pick #(
        .INPUTS      (INPUTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .req        (rx_tvalid),
        .ptr        (ptr_q),
        .pick_grant (pick_grant_s),
        .pick_index (pick_index_s),
        .pick_hit   (pick_hit_s)
    );

    // Beat detection and grant release conditions.
    always_comb begin
        beat_s = grant_valid_q & tx_tvalid & tx_tready;
        rel_s  = 1'b0;
        if (beat_s) begin
            rel_s = ((TLAST != 0) && tx_tlast) ||
                    ((MAX_BEATS != 0) && (beat_cnt_q == LAST_BEAT));
        end else begin
            // With no packet framing at all, an idle holder gives way.
            rel_s = (TLAST == 0) && (MAX_BEATS == 0) && !(|(rx_tvalid & grant_q));
        end
    end

    // Next-state logic for the FSM, pointer, beat counter and outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        beat_cnt_d    = beat_cnt_q;
        grant_d       = grant_q;
        grant_index_d = grant_index_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_hit_s) begin
                    state_d       = LOCKED;
                    ptr_d         = pick_index_s;
                    beat_cnt_d    = '0;
                    grant_d       = pick_grant_s;
                    grant_index_d = pick_index_s;
                    grant_valid_d = 1'b1;
                end else begin
                    state_d       = IDLE;
                end
            end
            LOCKED: begin
                if (rel_s && pick_hit_s) begin
                    ptr_d         = pick_index_s;
                    beat_cnt_d    = '0;
                    grant_d       = pick_grant_s;
                    grant_index_d = pick_index_s;
                    grant_valid_d = 1'b1;
                end else if (rel_s) begin
                    // ptr keeps the released index so it is served last next time.
                    state_d       = IDLE;
                    beat_cnt_d    = '0;
                    grant_d       = '0;
                    grant_index_d = '0;
                    grant_valid_d = 1'b0;
                end else if (beat_s && (MAX_BEATS != 0)) begin
                    beat_cnt_d    = beat_cnt_q + CNT_W'(1);
                end else begin
                    beat_cnt_d    = beat_cnt_q;
                end
            end
            default: begin
                state_d       = IDLE;
                beat_cnt_d    = '0;
                grant_d       = '0;
                grant_index_d = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any concurrent release.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            ptr_q         <= PTR_INIT;
            beat_cnt_q    <= '0;
            grant_q       <= '0;
            grant_index_q <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_index = grant_index_q;
    assign grant_valid = grant_valid_q;

endmodule : logic_axi4_stream_mux_arbiter

// File: tb/tb_logic_axi4_stream_mux_arbiter.sv
// ----------------------------------------------------------------------------
// tb_logic_axi4_stream_mux_arbiter
// Directed bench: dut_a is a 4-input tlast-framed arbiter, dut_b a 4-input
// arbiter releasing every 4 beats with tlast ignored. Inputs change #1 after
// the rising edge; outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_logic_axi4_stream_mux_arbiter;

    logic       aclk;
    logic       areset;
    logic [3:0] rx_tvalid;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       tx_tlast;
    logic [3:0] grant_a, grant_b;
    logic [1:0] index_a, index_b;
    logic       valid_a, valid_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic_axi4_stream_mux_arbiter #(
        .INPUTS(4), .TLAST(1), .MAX_BEATS(0)
    ) dut_a (
        .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
        .grant(grant_a), .grant_index(index_a), .grant_valid(valid_a)
    );

    logic_axi4_stream_mux_arbiter #(
        .INPUTS(4), .TLAST(0), .MAX_BEATS(4)
    ) dut_b (
        .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
        .grant(grant_b), .grant_index(index_b), .grant_valid(valid_b)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rx, input logic v, input logic r, input logic l);
        rx_tvalid = rx;
        tx_tvalid = v;
        tx_tready = r;
        tx_tlast  = l;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (grant_a !== 4'b0000 || index_a !== 2'd0 || valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_a: got grant=%b idx=%0d valid=%b, want 0000/0/0", grant_a, index_a, valid_a);
        end
        tests_run++;
        if (grant_b !== 4'b0000 || valid_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b: got grant=%b valid=%b, want 0000/0", grant_b, valid_b);
        end
    endtask

    task automatic test_latency();
        do_reset();
        drive(4'b0100, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_before: got valid=%b, want 0", valid_a);
        end
        tick();
        tests_run++;
        if (grant_a !== 4'b0100 || index_a !== 2'd2 || valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_grant: got grant=%b idx=%0d valid=%b, want 0100/2/1", grant_a, index_a, valid_a);
        end
        // Last beat with nobody else requesting returns to idle.
        drive(4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (grant_a !== 4'b0000 || valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_idle: got grant=%b valid=%b, want 0000/0", grant_a, valid_a);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx;
        do_reset();
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (index_a !== 2'd0 || valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_first: got idx=%0d valid=%b, want 0/1", index_a, valid_a);
        end
        drive(4'b1111, 1'b1, 1'b1, 1'b1);
        exp_idx = 2'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_idx = exp_idx + 2'd1;
            tests_run++;
            if (index_a !== exp_idx || valid_a !== 1'b1 || grant_a !== (4'b0001 << exp_idx)) begin
                tests_failed++;
                $display("FAIL rr_seq[%0d]: got idx=%0d grant=%b valid=%b, want idx=%0d valid=1",
                         k, index_a, grant_a, valid_a, exp_idx);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(4'b1010, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (index_a !== 2'd1) begin
            tests_failed++;
            $display("FAIL stall_first: got idx=%0d, want 1", index_a);
        end
        // beat 1, beat 2, two stalled cycles showing tlast, then the tlast beat.
        drive(4'b1010, 1'b1, 1'b1, 1'b0); tick();
        drive(4'b1010, 1'b1, 1'b1, 1'b0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(4'b1010, 1'b1, 1'b0, 1'b1);
            tick();
            tests_run++;
            if (index_a !== 2'd1 || grant_a !== 4'b0010 || valid_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got idx=%0d grant=%b valid=%b, want 1/0010/1",
                         k, index_a, grant_a, valid_a);
            end
        end
        drive(4'b1010, 1'b1, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (index_a !== 2'd3 || grant_a !== 4'b1000 || valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_switch: got idx=%0d grant=%b valid=%b, want 3/1000/1", index_a, grant_a, valid_a);
        end
    endtask

    task automatic test_max_beats();
        logic [1:0] exp_idx;
        do_reset();
        drive(4'b0101, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (index_b !== 2'd0 || valid_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL max_first: got idx=%0d valid=%b, want 0/1", index_b, valid_b);
        end
        // tlast held high to show it is ignored in this configuration.
        drive(4'b0101, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_idx = (((k / 4) % 2) == 1) ? 2'd2 : 2'd0;
            tests_run++;
            if (index_b !== exp_idx || valid_b !== 1'b1) begin
                tests_failed++;
                $display("FAIL max_seq[%0d]: got idx=%0d valid=%b, want idx=%0d valid=1",
                         k, index_b, valid_b, exp_idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(4'b0010, 1'b1, 1'b1, (k % 2) == 1);
            tick();
            tests_run++;
            if (grant_a !== 4'b0010 || index_a !== 2'd1 || valid_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got grant=%b idx=%0d valid=%b, want 0010/1/1",
                         k, grant_a, index_a, valid_a);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b1000, 1'b1, 1'b1, 1'b0);
        tick();
        areset = 1'b1;
        tick();
        tests_run++;
        if (grant_a !== 4'b0000 || valid_a !== 1'b0 || index_a !== 2'd0) begin
            tests_failed++;
            $display("FAIL midreset_drop: got grant=%b idx=%0d valid=%b, want 0000/0/0", grant_a, index_a, valid_a);
        end
        areset = 1'b0;
        drive(4'b1001, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (grant_a !== 4'b0001 || index_a !== 2'd0 || valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_regrant: got grant=%b idx=%0d valid=%b, want 0001/0/1", grant_a, index_a, valid_a);
        end
        // Release beat and reset together: reset must win over re-arbitration.
        drive(4'b1001, 1'b1, 1'b1, 1'b1);
        areset = 1'b1;
        tick();
        tests_run++;
        if (grant_a !== 4'b0000 || valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL rel_and_reset: got grant=%b valid=%b, want 0000/0", grant_a, valid_a);
        end
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_latency();
        test_round_robin();
        test_stall();
        test_max_beats();
        test_back_to_back();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_logic_axi4_stream_mux_arbiter
